// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the unified memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_t;

  localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-way round-robin grant between fetch and data requesters
module mem_arb_rr (
  input  logic if_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);
  import mem_arb_pkg::*;

  always_comb begin
    grant_valid = if_req | d_req;
    // On a tie the requester that was not served last wins
    if (if_req && d_req) begin
      grant_id = ~last_grant;
    end else if (d_req) begin
      grant_id = DATA;
    end else begin
      grant_id = FETCH;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one req/ack memory port between fetch and load/store
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_be,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);
  import mem_arb_pkg::*;

  localparam int CW = $clog2(TIMEOUT);

  state_t        r_state;
  owner_t        r_owner;
  owner_t        r_last;
  logic [CW-1:0] r_cnt;
  logic          w_grant_valid;
  logic          w_grant_id;
  logic          w_last;

  assign w_last = r_last;

  mem_arb_rr u_rr (
    .if_req      (if_req),
    .d_req       (d_req),
    .last_grant  (w_last),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= FETCH;
      r_last    <= FETCH;
      r_cnt     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_owner <= owner_t'(w_grant_id);
            r_last  <= owner_t'(w_grant_id);
            r_cnt   <= '0;
            mem_req <= 1'b1;
            if (w_grant_id == DATA) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_be    <= d_be;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_be    <= FETCH_BE;
            end
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack || (r_cnt == CW'(TIMEOUT - 1))) begin
            // A timed-out read returns zero; writes never touch the rdata holders
            mem_req <= 1'b0;
            err     <= ~mem_ack;
            if (r_owner == DATA) begin
              d_done <= 1'b1;
              if (!mem_we) begin
                d_rdata <= mem_ack ? mem_rdata : '0;
              end
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if_done <= 1'b0;
          d_done  <= 1'b0;
          err     <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_done, d_done, err, mem_req, mem_we;
  logic [3:0]  mem_be;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cyc = 0;

  // Reference state: who was served last and what each requester last received
  logic        m_last;
  logic [31:0] m_if_rdata, m_d_rdata;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called with the DUT idle and requests presented; returns with the DUT idle again.
  // lat<0 means memory never acks.
  task automatic run_txn(input int lat, input bit drop, input logic [31:0] rd, output logic own);
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    logic [3:0]  e_be;
    int          nbusy;
    bit          to;
    own = (if_req && d_req) ? ~m_last : d_req;
    if (own) begin
      e_addr = d_addr; e_we = d_we; e_be = d_be; e_wdata = d_wdata;
    end else begin
      e_addr = if_addr; e_we = 1'b0; e_be = 4'hF; e_wdata = 32'h0;
    end
    m_last = own;
    to = (lat < 0);
    nbusy = to ? TMO : lat + 1;
    @(posedge clk); #1;
    chk("grant_mem_req", mem_req, 1'b1);
    chk("grant_addr", mem_addr, e_addr);
    chk("grant_we", mem_we, e_we);
    chk("grant_be", mem_be, e_be);
    if (own) chk("grant_wdata", mem_wdata, e_wdata);
    for (int i = 0; i < nbusy; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        chk("busy_mem_req", mem_req, 1'b1);
        chk("busy_addr_stable", mem_addr, e_addr);
        chk("busy_we_stable", mem_we, e_we);
        chk("busy_be_stable", mem_be, e_be);
        if (own) chk("busy_wdata_stable", mem_wdata, e_wdata);
      end
      chk("busy_no_done", {if_done, d_done}, 2'b00);
      if (!to && i == nbusy - 1) begin
        mem_ack = 1'b1; mem_rdata = rd;
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = $urandom;
    if (!own) m_if_rdata = to ? 32'h0 : rd;
    else if (!e_we) m_d_rdata = to ? 32'h0 : rd;
    chk("done_mem_req", mem_req, 1'b0);
    chk("done_if_done", if_done, !own);
    chk("done_d_done", d_done, own);
    chk("done_err", err, to);
    chk("done_if_rdata", if_rdata, m_if_rdata);
    chk("done_d_rdata", d_rdata, m_d_rdata);
    done_cyc = cyc;
    if (drop) begin
      if (own) d_req = 1'b0; else if_req = 1'b0;
    end
    @(posedge clk); #1;
    chk("idle_dones_low", {if_done, d_done}, 2'b00);
    chk("idle_err_low", err, 1'b0);
    chk("idle_mem_req", mem_req, 1'b0);
  endtask

  initial begin
    logic own;
    int   prev, lat;
    logic pred;
    reset = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; mem_rdata = 0;
    m_last = 1'b0; m_if_rdata = 0; m_d_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", mem_be, 4'h0);
    chk("rst_dones_err", {if_done, d_done, err}, 3'b000);
    chk("rst_rdata", if_rdata | d_rdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_req", mem_req, 1'b0);

    // Tie straight after reset: D, F, D with both requests held
    if_req = 1; if_addr = 32'h0000_0020;
    d_req = 1; d_we = 0; d_addr = 32'h0000_0400; d_be = 4'hF; d_wdata = 32'h0;
    run_txn(1, 0, 32'h1111_AAAA, own);
    chk("tie_order_1st", own, 1'b1);
    run_txn(1, 0, 32'h2222_BBBB, own);
    chk("tie_order_2nd", own, 1'b0);
    run_txn(1, 1, 32'h3333_CCCC, own);
    chk("tie_order_3rd", own, 1'b1);
    if_req = 0;
    @(posedge clk); #1;
    chk("tie_quiet", mem_req, 1'b0);

    // Single fetch with same-cycle ack
    if_req = 1; if_addr = 32'h0000_0010;
    run_txn(0, 1, 32'h0050_0093, own);
    chk("single_fetch_rdata", if_rdata, 32'h0050_0093);

    // Write held 4 cycles on the port, d_rdata untouched
    d_req = 1; d_we = 1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    run_txn(3, 1, 32'h5555_5555, own);
    chk("write_keeps_d_rdata", d_rdata, 32'h3333_CCCC);
    d_we = 0;

    // Timeout then a late ack that must be ignored
    if_req = 1; if_addr = 32'h0000_0080;
    run_txn(-1, 1, 32'h0, own);
    @(posedge clk); #1;
    mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    mem_ack = 0;
    chk("late_ack_no_done", {if_done, d_done, err}, 3'b000);
    chk("late_ack_no_req", mem_req, 1'b0);
    chk("late_ack_rdata", if_rdata, 32'h0);

    // Asynchronous reset two cycles into a data read
    d_req = 1; d_we = 0; d_addr = 32'h0000_0200;
    @(posedge clk); #1;
    chk("rstbusy_req_up", mem_req, 1'b1);
    @(posedge clk); #1;
    chk("rstbusy_req_held", mem_req, 1'b1);
    #3 reset = 1'b1;
    #1;
    chk("rstbusy_async_req", mem_req, 1'b0);
    chk("rstbusy_async_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    chk("rstbusy_no_done", d_done, 1'b0);
    chk("rstbusy_rdata_clear", if_rdata | d_rdata, 32'h0);
    reset = 1'b0; d_req = 0;
    m_last = 1'b0; m_if_rdata = 0; m_d_rdata = 0;
    if_req = 1; if_addr = 32'h0000_0040;
    run_txn(0, 1, 32'h0000_0013, own);

    // Back-to-back fetch with immediate acks
    if_req = 1; if_addr = 32'h0;
    run_txn(0, 0, 32'hA000_0000, own);
    prev = done_cyc;
    if_addr = 32'h4;
    run_txn(0, 0, 32'hA000_0004, own);
    chk("b2b_period_1", done_cyc - prev, 3);
    prev = done_cyc;
    if_addr = 32'h8;
    run_txn(0, 1, 32'hA000_0008, own);
    chk("b2b_period_2", done_cyc - prev, 3);

    // Randomized traffic; pending non-owner requests stay held across transactions
    for (int n = 0; n < 40; n++) begin
      if (!if_req && ($urandom_range(0, 1) == 1 || !d_req)) begin
        if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1; d_we = 1'($urandom); d_addr = $urandom;
        d_wdata = $urandom; d_be = 4'($urandom);
      end
      pred = (if_req && d_req) ? ~m_last : d_req;
      if ($urandom_range(0, 7) == 0 && !(pred && d_we)) lat = -1;
      else lat = int'($urandom_range(0, 4));
      run_txn(lat, 1, $urandom, own);
      chk("rand_owner", own, pred);
    end
    if_req = 0; d_req = 0;
    @(posedge clk); #1;
    chk("final_idle", mem_req, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
